// File: rtl/dm_arbiter.sv
// dm_arbiter: round-robin arbiter and sequencer sharing one single-port data
// memory between core_count processor cores.
//
// A request from core i is held on req[i] until ack[i] pulses. The arbiter
// captures the winning request, issues one memory strobe cycle, waits the
// fixed read latency for reads, then pulses ack to the owning core. Read data
// is returned on rdata in the ack cycle and held until the next read.
//
// Ports
//   clk        system clock
//   reset      synchronous, active-high reset
//   req        per-core request, held until ack
//   req_we     per-core write(1)/read(0) select, valid while req
//   req_addr   packed addresses, core i at [i*reg_width +: reg_width]
//   req_wdata  packed write data, same packing
//   mem_rdata  data-memory read data, valid mem_lat cycles after mem_read
//   ack        one-hot, one-cycle completion pulse
//   rdata      read data, valid in the ack cycle of a read
//   mem_addr   data-memory address
//   mem_wdata  data-memory write data
//   mem_write  data-memory write strobe
//   mem_read   data-memory read strobe
//   busy       high in every state except IDLE
//   owner      index of the core currently served
//
// state  | meaning
// IDLE   | search req from rr_ptr, capture the winner
// ACCESS | one strobe cycle on the memory
// WAIT   | read latency countdown, capture mem_rdata on the last cycle
// ACK    | one-cycle ack pulse, advance rr_ptr past the owner

module dm_arbiter #(
   parameter int reg_width   = 12,
   parameter int core_count  = 4,
   parameter int owner_width = 2,
   parameter int mem_lat     = 1
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [core_count-1:0]           req,
   input  logic [core_count-1:0]           req_we,
   input  logic [core_count*reg_width-1:0] req_addr,
   input  logic [core_count*reg_width-1:0] req_wdata,
   input  logic [reg_width-1:0]            mem_rdata,
   output logic [core_count-1:0]           ack,
   output logic [reg_width-1:0]            rdata,
   output logic [reg_width-1:0]            mem_addr,
   output logic [reg_width-1:0]            mem_wdata,
   output logic                            mem_write,
   output logic                            mem_read,
   output logic                            busy,
   output logic [owner_width-1:0]          owner
);

   typedef enum logic [1:0] {IDLE, ACCESS, WAIT, ACK} state_t;

   state_t                 state, state_n;
   logic [2:0]             cnt, cnt_n;
   logic                   hold_we, hold_we_n;
   logic [owner_width-1:0] rr_ptr, rr_ptr_n;
   logic [owner_width-1:0] owner_n;
   logic [core_count-1:0]  ack_n;
   logic [reg_width-1:0]   rdata_n, mem_addr_n, mem_wdata_n;
   logic                   mem_write_n, mem_read_n, busy_n;

   logic                   found;
   logic [owner_width-1:0] win, cand;

   logic [reg_width-1:0]   addr_arr  [core_count];
   logic [reg_width-1:0]   wdata_arr [core_count];

   for (genvar g = 0; g < core_count; g++) begin : g_unpack
      assign addr_arr[g]  = req_addr[g*reg_width +: reg_width];
      assign wdata_arr[g] = req_wdata[g*reg_width +: reg_width];
   end

   // Index base+off reduced modulo core_count (off < core_count).
   function automatic logic [owner_width-1:0] wrap_idx(input logic [owner_width-1:0] base,
                                                       input int off);
      int sum;
      sum = int'(base) + off;
      if (sum >= core_count) sum = sum - core_count;
      return owner_width'(sum);
   endfunction

   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      hold_we_n   = hold_we;
      rr_ptr_n    = rr_ptr;
      owner_n     = owner;
      ack_n       = '0;
      rdata_n     = rdata;
      mem_addr_n  = mem_addr;
      mem_wdata_n = mem_wdata;
      mem_write_n = 1'b0;
      mem_read_n  = 1'b0;
      found       = 1'b0;
      win         = '0;
      cand        = '0;

      for (int i = 0; i < core_count; i++) begin
         cand = wrap_idx(rr_ptr, i);
         if (!found && req[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end

      case (state)
         IDLE: begin
            if (found) begin
               // mem_addr/mem_wdata double as the holding registers; the
               // strobe is registered so it appears in the ACCESS cycle.
               owner_n     = win;
               hold_we_n   = req_we[win];
               mem_addr_n  = addr_arr[win];
               mem_wdata_n = wdata_arr[win];
               if (req_we[win]) mem_write_n = 1'b1;
               else             mem_read_n  = 1'b1;
               state_n     = ACCESS;
            end
         end
         ACCESS: begin
            if (hold_we) begin
               ack_n[owner] = 1'b1;
               state_n      = ACK;
            end else begin
               cnt_n   = 3'(mem_lat);
               state_n = WAIT;
            end
         end
         WAIT: begin
            cnt_n = cnt - 3'd1;
            if (cnt == 3'd1) begin
               rdata_n      = mem_rdata;
               ack_n[owner] = 1'b1;
               state_n      = ACK;
            end
         end
         ACK: begin
            rr_ptr_n = (owner == owner_width'(core_count - 1)) ? '0 : owner + 1'b1;
            state_n  = IDLE;
         end
         default: state_n = IDLE;
      endcase

      busy_n = (state_n != IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         hold_we   <= 1'b0;
         rr_ptr    <= '0;
         owner     <= '0;
         ack       <= '0;
         rdata     <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_write <= 1'b0;
         mem_read  <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         hold_we   <= hold_we_n;
         rr_ptr    <= rr_ptr_n;
         owner     <= owner_n;
         ack       <= ack_n;
         rdata     <= rdata_n;
         mem_addr  <= mem_addr_n;
         mem_wdata <= mem_wdata_n;
         mem_write <= mem_write_n;
         mem_read  <= mem_read_n;
         busy      <= busy_n;
      end
   end

endmodule

// File: tb/tb_dm_arbiter.sv
// Testbench for dm_arbiter. A transaction-level reference model predicts,
// from the request lines the bench drives, which core wins each arbitration
// and in which cycles the strobe and ack must appear; predictions go into a
// scoreboard queue that the monitor drains as the DUT responds.

module tb_dm_arbiter;
   localparam int RW  = 12;
   localparam int CC  = 4;
   localparam int OW  = 2;
   localparam int LAT = 3;

   logic            clk = 1'b0;
   logic            reset;
   logic [CC-1:0]   req, req_we;
   logic [CC*RW-1:0] req_addr, req_wdata;
   logic [RW-1:0]   mem_rdata;
   logic [CC-1:0]   ack;
   logic [RW-1:0]   rdata, mem_addr, mem_wdata;
   logic            mem_write, mem_read, busy;
   logic [OW-1:0]   owner;

   always #5 clk = ~clk;

   dm_arbiter #(.reg_width(RW), .core_count(CC), .owner_width(OW), .mem_lat(LAT)) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .mem_rdata (mem_rdata),
      .ack       (ack),
      .rdata     (rdata),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_write (mem_write),
      .mem_read  (mem_read),
      .busy      (busy),
      .owner     (owner)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          core;
      bit          we;
      logic [11:0] addr;
      logic [11:0] wdata;
      logic [11:0] rdata;
      int          issue_cyc;
      int          ack_cyc;
   } txn_t;

   txn_t          sb[$];
   logic [CC-1:0] drop_mask = '0;
   logic          end_req = 1'b0;
   logic          end_done = 1'b0;
   int            tmo_cnt = 0;
   int            n_vec = 0;
   int            n_fail = 0;
   int            free_cyc = 0;

   function automatic logic [11:0] init_val(input int a);
      return (a == 32) ? 12'h5A5 : 12'((a * 37 + 5) ^ 32'h3C3);
   endfunction

   // ---------------- memory with LAT-cycle read pipeline ----------------
   logic [11:0] mem [4096];
   logic        rd_v = 1'b0;
   logic [11:0] rd_a = '0;
   logic [11:0] pipe [LAT];

   initial begin
      for (int a = 0; a < 4096; a++) mem[a] = init_val(a);
      forever begin
         @(negedge clk);
         if (mem_write === 1'b1) mem[mem_addr] = mem_wdata;
         rd_v = (mem_read === 1'b1);
         rd_a = mem_addr;
      end
   end

   initial begin
      for (int j = 0; j < LAT; j++) pipe[j] = '0;
      mem_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         for (int j = LAT - 1; j > 0; j--) pipe[j] = pipe[j-1];
         pipe[0]   = rd_v ? mem[rd_a] : 12'($urandom);
         mem_rdata = pipe[LAT-1];
      end
   end

   // ---------------- checker ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference model + monitor ----------------
   initial begin
      logic [11:0] mirror [4096];
      int          ptr;
      bit          have_cur;
      int          cur_core, cur_issue, cur_ack;
      logic [11:0] hold;
      bit          rst_prev, mon_en, exp_busy;
      logic [31:0] exp_ack;
      txn_t        t;

      for (int a = 0; a < 4096; a++) mirror[a] = init_val(a);
      ptr = 0; have_cur = 0; cur_core = 0; cur_issue = 0; cur_ack = 0;
      hold = '0; rst_prev = 0; mon_en = 0;

      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (rst_prev) begin
               chk("rst_ack",       32'(ack),       32'd0);
               chk("rst_rdata",     32'(rdata),     32'd0);
               chk("rst_mem_addr",  32'(mem_addr),  32'd0);
               chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
               chk("rst_mem_write", 32'(mem_write), 32'd0);
               chk("rst_mem_read",  32'(mem_read),  32'd0);
               chk("rst_busy",      32'(busy),      32'd0);
               chk("rst_owner",     32'(owner),     32'd0);
            end
            chk("strobe_excl", 32'(mem_read & mem_write), 32'd0);
            exp_busy = have_cur && (cyc > cur_issue) && (cyc <= cur_ack);
            chk("busy", 32'(busy), 32'(exp_busy));
            if (exp_busy) chk("owner", 32'(owner), 32'(cur_core));

            if (sb.size() != 0 && cyc == sb[0].issue_cyc + 1) begin
               t = sb[0];
               chk("strobe_write", 32'(mem_write), 32'(t.we));
               chk("strobe_read",  32'(mem_read),  32'(!t.we));
               chk("mem_addr",     32'(mem_addr),  32'(t.addr));
               if (t.we) chk("mem_wdata", 32'(mem_wdata), 32'(t.wdata));
            end else begin
               chk("strobe_idle", 32'({mem_read, mem_write}), 32'd0);
            end

            exp_ack = '0;
            if (sb.size() != 0 && cyc == sb[0].ack_cyc) begin
               t = sb.pop_front();
               exp_ack = 32'd1 << t.core;
               if (!t.we) hold = t.rdata;
            end
            chk("ack", 32'(ack), exp_ack);
            chk("rdata", 32'(rdata), 32'(hold));
            drop_mask = ack;
         end

         if (reset === 1'b1) begin
            sb.delete();
            have_cur = 0;
            ptr      = 0;
            hold     = '0;
            free_cyc = cyc + 1;
            mon_en   = 1;
         end else if (cyc >= free_cyc && req != '0) begin
            for (int k = 0; k < CC; k++) begin
               int c;
               c = (ptr + k) % CC;
               if (req[c] && !have_cur || req[c] && cyc >= free_cyc) begin
                  t.core  = c;
                  t.we    = req_we[c];
                  t.addr  = req_addr[c*RW +: RW];
                  t.wdata = req_wdata[c*RW +: RW];
                  if (t.we) mirror[t.addr] = t.wdata;
                  t.rdata     = mirror[t.addr];
                  t.issue_cyc = cyc;
                  t.ack_cyc   = cyc + 2 + (t.we ? 0 : LAT);
                  sb.push_back(t);
                  free_cyc  = t.ack_cyc + 1;
                  ptr       = (c + 1) % CC;
                  have_cur  = 1;
                  cur_core  = c;
                  cur_issue = t.issue_cyc;
                  cur_ack   = t.ack_cyc;
                  break;
               end
            end
         end
         rst_prev = (reset === 1'b1);

         if (end_req && !end_done) begin
            chk("sb_drained", 32'(sb.size()), 32'd0);
            chk("timeouts",   32'(tmo_cnt),   32'd0);
            end_done = 1'b1;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
      req = req & ~drop_mask;
   endtask

   task automatic set_req(input int k, input bit we, input logic [11:0] addr,
                          input logic [11:0] wdata);
      req[k]               = 1'b1;
      req_we[k]            = we;
      req_addr[k*RW +: RW]  = addr;
      req_wdata[k*RW +: RW] = wdata;
   endtask

   task automatic quiet(input int max_cyc);
      int n;
      n = 0;
      while ((req != '0 || sb.size() != 0 || cyc < free_cyc) && n < max_cyc) begin
         step();
         n++;
      end
      if (n >= max_cyc) tmo_cnt++;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req   = '0;
      step();
      step();
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // single write from core 2, then rr_ptr=3 so core 3 beats core 0
      set_req(2, 1'b1, 12'h010, 12'hABC);
      quiet(100);
      set_req(0, 1'b0, 12'h010, 12'h000);
      set_req(3, 1'b0, 12'h011, 12'h000);
      quiet(100);

      // single read of a known location
      set_req(0, 1'b0, 12'h020, 12'h000);
      quiet(100);

      // all four cores read at once right after reset
      do_reset();
      for (int k = 0; k < CC; k++) set_req(k, 1'b0, 12'(12'h020 + k), 12'h000);
      quiet(200);

      // fairness: core 0 requests continuously, core 3 once
      do_reset();
      set_req(0, 1'b1, 12'h040, 12'h111);
      set_req(3, 1'b1, 12'h043, 12'h333);
      for (int n = 0; n < 30; n++) begin
         step();
         if (!req[0]) set_req(0, 1'b0, 12'h043, 12'h000);
      end
      quiet(100);

      // reset during WAIT abandons the read, then a fresh access completes
      set_req(2, 1'b0, 12'h030, 12'h000);
      step();
      step();
      reset = 1'b1;
      req   = '0;
      step();
      reset = 1'b0;
      step();
      set_req(1, 1'b1, 12'h030, 12'h777);
      quiet(100);
      set_req(1, 1'b0, 12'h030, 12'h000);
      quiet(100);

      // random traffic
      for (int n = 0; n < 1500; n++) begin
         step();
         for (int k = 0; k < CC; k++)
            if (!req[k] && $urandom_range(0, 3) == 0)
               set_req(k, 1'($urandom), 12'($urandom_range(0, 31)), 12'($urandom));
      end
      quiet(300);

      end_req = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
